ray_batch_sequencer: RTL and testbench

- Upstream driver and downstream reducer for the primitive test stage: accepts one Ray, walks the scene's primitive batches, and issues one batch address per cycle to primitive memory.
- Each returned batch goes to the closest-hit / any-hit test unit; the block reduces the per-batch results across all batches.
- Emits one final HitData (closest mode) or hit flag (any-hit / shadow mode) per ray through a valid/ready handshake.
- Sits between the ray generator/shader and the primitive test units.

---
 rtl/ray_batch_sequencer_pkg.sv | 50 +++++
 rtl/ray_batch_sequencer_if.sv | 40 ++++
 rtl/ray_batch_sequencer_hit_accumulator.sv | 34 +++
 rtl/ray_batch_sequencer.sv | 108 ++++++++++
 tb/tb_ray_batch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_batch_sequencer_pkg.sv
// Shared types for the primitive test stage: fixed-point scalar, Ray, HitData,
// the sequencer state encoding and the fixed-point helpers.
package ray_batch_sequencer_pkg;

    // Signed Q16.16 fixed point
    typedef logic signed [31:0] Fixed;

    typedef struct packed {
        Fixed ox;
        Fixed oy;
        Fixed oz;
        Fixed dx;
        Fixed dy;
        Fixed dz;
    } Ray;

    typedef struct packed {
        logic        bHit;
        Fixed        T;
        logic [23:0] color;
    } HitData;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    localparam Fixed FIXED_INF = 32'sh7FFF_FFFF;

    function automatic Fixed FixedInf();
        return FIXED_INF;
    endfunction

    // Signed strict less-than on Fixed
    function automatic logic fixed_lt(input Fixed a, input Fixed b);
        return a < b;
    endfunction

    // Empty accumulator value: no hit, infinitely far
    function automatic HitData hit_none();
        HitData h;
        h.bHit  = 1'b0;
        h.T     = FixedInf();
        h.color = '0;
        return h;
    endfunction

endpackage

// File: rtl/ray_batch_sequencer_if.sv
// Ray in / batch fetch / per-batch result / final result signals of the sequencer.
// master = sequencer side, slave = surrounding shader / memory / test units.
interface ray_batch_sequencer_if #(
    parameter int BATCH_W = 8
);
    import ray_batch_sequencer_pkg::*;

    logic               ray_in_valid;
    logic               ray_in_ready;
    Ray                 ray_in;
    logic               any_hit_mode;
    logic [BATCH_W-1:0] num_batches;

    logic               prim_rd_en;
    logic [BATCH_W-1:0] prim_addr;
    Ray                 ray_out;

    HitData             unit_hit;
    logic               unit_any_hit;

    logic               out_valid;
    logic               out_ready;
    HitData             out_hit;
    logic               out_any_hit;

    modport master (
        input  ray_in_valid, ray_in, any_hit_mode, num_batches,
        input  unit_hit, unit_any_hit, out_ready,
        output ray_in_ready, prim_rd_en, prim_addr, ray_out,
        output out_valid, out_hit, out_any_hit
    );

    modport slave (
        output ray_in_valid, ray_in, any_hit_mode, num_batches,
        output unit_hit, unit_any_hit, out_ready,
        input  ray_in_ready, prim_rd_en, prim_addr, ray_out,
        input  out_valid, out_hit, out_any_hit
    );

endinterface

// File: rtl/ray_batch_sequencer_hit_accumulator.sv
// Reduces per-batch test results for one ray: strict signed minimum of T over
// hitting batches (earlier batch wins ties) in closest mode, OR in any-hit mode.
module hit_accumulator
    import ray_batch_sequencer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   retire,
    input  logic   any_mode,
    input  HitData hit_in,
    input  logic   any_in,
    output HitData acc_hit,
    output logic   acc_any
);

    // Accumulator update: clear on ray accept, fold in one batch per retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hit <= hit_none();
            acc_any <= 1'b0;
        end else if (clear) begin
            acc_hit <= hit_none();
            acc_any <= 1'b0;
        end else if (retire) begin
            if (any_mode) begin
                acc_any <= acc_any | any_in;
            end else if (hit_in.bHit && fixed_lt(hit_in.T, acc_hit.T)) begin
                acc_hit <= hit_in;
            end
        end
    end

endmodule

// File: rtl/ray_batch_sequencer.sv
// Accepts one ray, issues one primitive batch fetch per cycle, tracks in-flight
// batches with a tag shift register and reduces their results into one final
// closest hit or any-hit flag, returned through a valid/ready handshake.
module ray_batch_sequencer
    import ray_batch_sequencer_pkg::*;
#(
    parameter int BATCH_W     = 8,
    parameter int MEM_LATENCY = 1,
    parameter int HIT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ray_batch_sequencer_if.master bus
);

    localparam int TAG_D = MEM_LATENCY + HIT_LATENCY;
    // Every tag position except the output one; when these are empty the
    // last in-flight batch retires this cycle.
    localparam logic [TAG_D-1:0]   TAG_REST = {TAG_D{1'b1}} >> 1;
    localparam logic [BATCH_W-1:0] IDX_ONE  = BATCH_W'(1);

    seq_state_e         state, state_nxt;
    logic [BATCH_W-1:0] issue_idx;
    logic [BATCH_W-1:0] num_q;
    logic               any_q;
    Ray                 ray_q;
    logic [TAG_D-1:0]   tag;

    logic   accept, issuing, last_issue, retire, early_out, drained;
    HitData acc_hit;
    logic   acc_any;

    assign accept    = (state == SEQ_IDLE) && bus.ray_in_valid;
    assign issuing   = (state == SEQ_ISSUE);
    assign retire    = tag[TAG_D-1];
    assign early_out = any_q && retire && bus.unit_any_hit;
    assign drained   = (tag & TAG_REST) == '0;
    // One bit wider so a full 2^BATCH_W-1 batch count never wraps
    assign last_issue = ({1'b0, issue_idx} + {{BATCH_W{1'b0}}, 1'b1}) == {1'b0, num_q};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEQ_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE:  if (bus.ray_in_valid)
                           state_nxt = (bus.num_batches == '0) ? SEQ_DONE : SEQ_ISSUE;
            SEQ_ISSUE: if (early_out || last_issue) state_nxt = SEQ_DRAIN;
            SEQ_DRAIN: if (drained)                 state_nxt = SEQ_DONE;
            SEQ_DONE:  if (bus.out_ready)           state_nxt = SEQ_IDLE;
            default:   state_nxt = SEQ_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.ray_in_ready = (state == SEQ_IDLE);
        bus.prim_rd_en   = issuing;
        bus.prim_addr    = issuing ? issue_idx : '0;
        bus.out_valid    = (state == SEQ_DONE);
    end

    // Ray latch, issue counter and in-flight tag shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ray_q     <= '0;
            any_q     <= 1'b0;
            num_q     <= '0;
            issue_idx <= '0;
            tag       <= '0;
        end else begin
            tag <= (tag << 1) | TAG_D'(issuing);
            if (accept) begin
                ray_q     <= bus.ray_in;
                any_q     <= bus.any_hit_mode;
                num_q     <= bus.num_batches;
                issue_idx <= '0;
            end else if (issuing) begin
                issue_idx <= issue_idx + IDX_ONE;
            end
        end
    end

    hit_accumulator u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .retire   (retire),
        .any_mode (any_q),
        .hit_in   (bus.unit_hit),
        .any_in   (bus.unit_any_hit),
        .acc_hit  (acc_hit),
        .acc_any  (acc_any)
    );

    // Result and held ray; acc is frozen in DONE since nothing is in flight
    always_comb begin
        bus.ray_out     = ray_q;
        bus.out_hit     = acc_hit;
        bus.out_any_hit = any_q ? acc_any : acc_hit.bHit;
    end

endmodule

// File: tb/tb_ray_batch_sequencer.sv
// Directed bench for ray_batch_sequencer: a batch table plus a two-stage
// memory/test-unit model answers fetches, expected results go into a
// scoreboard and a monitor compares them on each output handshake.
module tb_ray_batch_sequencer;
    import ray_batch_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ray_batch_sequencer_if #(.BATCH_W(8)) bus();

    ray_batch_sequencer #(
        .BATCH_W     (8),
        .MEM_LATENCY (1),
        .HIT_LATENCY (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     mode;
        HitData h;
        bit     any;
        int     id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bit          tb_hit[8];
    Fixed        tb_T[8];
    logic [23:0] tb_col[8];

    // Driven when no batch result is due; must never be folded in
    localparam HitData GARB = '{bHit: 1'b1, T: 32'sh8000_0001, color: 24'hBAD0BA};
    localparam HitData MISS = '{bHit: 1'b0, T: 32'sh7FFF_FFFF, color: 24'h0};

    function automatic Fixed fx(input int i);
        return Fixed'(i <<< 16);
    endfunction

    function automatic HitData hd(input bit h, input Fixed t, input logic [23:0] c);
        HitData r;
        r.bHit  = h;
        r.T     = t;
        r.color = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Memory (1 cycle) + test unit (1 cycle) model
    logic [7:0] s1, s2;
    logic       s1v, s2v;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
            s1  <= '0;
            s2  <= '0;
        end else begin
            s1v <= bus.prim_rd_en;
            s1  <= bus.prim_addr;
            s2v <= s1v;
            s2  <= s1;
        end
    end

    always_comb begin
        bus.unit_hit     = GARB;
        bus.unit_any_hit = 1'b1;
        if (s2v) begin
            bus.unit_hit     = hd(tb_hit[s2[2:0]], tb_T[s2[2:0]], tb_col[s2[2:0]]);
            bus.unit_any_hit = tb_hit[s2[2:0]];
        end
    end

    // Scoreboard monitor: compare on each completed output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got hit=0x%0h any=%0b, want none", bus.out_hit, bus.out_any_hit);
            end else begin
                e = sb.pop_front();
                if (!e.mode)
                    chk($sformatf("out_hit_%0d", e.id), bus.out_hit, e.h);
                chk($sformatf("out_any_%0d", e.id), bus.out_any_hit, e.any);
            end
        end
    end

    task automatic clr_tab();
        for (int i = 0; i < 8; i++) begin
            tb_hit[i] = 1'b0;
            tb_T[i]   = fx(100);
            tb_col[i] = 24'h0;
        end
    endtask

    task automatic set_b(input int i, input bit h, input Fixed t, input logic [23:0] c);
        tb_hit[i] = h;
        tb_T[i]   = t;
        tb_col[i] = c;
    endtask

    // Offer one ray, follow it to its result, check issue order/count,
    // latency, optional stall stability and the release handshake.
    task automatic run_ray(input int id, input bit mode, input int n, input HitData eh,
                           input bit ea, input int exp_lat, input int min_iss,
                           input int max_iss, input int stall);
        Ray     r;
        int     c;
        int     issued;
        bit     addr_ok;
        bit     stable;
        HitData snap;
        logic   snap_any;
        r = '{ox: fx(id), oy: fx(id + 1), oz: fx(-id), dx: fx(1), dy: fx(0), dz: fx(-1)};
        bus.ray_in       = r;
        bus.any_hit_mode = mode;
        bus.num_batches  = 8'(n);
        bus.out_ready    = (stall == 0);
        bus.ray_in_valid = 1'b1;
        chk($sformatf("ready_idle_%0d", id), bus.ray_in_ready, 1);
        sb.push_back('{mode: mode, h: eh, any: ea, id: id});
        @(posedge clk); #1;
        bus.ray_in_valid = 1'b0;
        c       = 1;
        issued  = 0;
        addr_ok = 1'b1;
        chk($sformatf("ray_out_%0d", id), bus.ray_out == r, 1);
        while (!bus.out_valid && c < 1000) begin
            if (bus.prim_rd_en) begin
                if (bus.prim_addr != 8'(issued)) addr_ok = 1'b0;
                issued++;
            end
            @(posedge clk); #1;
            c++;
        end
        chk($sformatf("done_reached_%0d", id), bus.out_valid, 1);
        if (exp_lat >= 0) chk($sformatf("latency_%0d", id), c, exp_lat);
        chk($sformatf("addr_order_%0d", id), addr_ok, 1);
        chk($sformatf("issue_count_%0d(n=%0d)", id, issued), issued >= min_iss && issued <= max_iss, 1);
        chk($sformatf("busy_%0d", id), {bus.ray_in_ready, bus.prim_rd_en}, 2'b00);
        if (stall > 0) begin
            snap     = bus.out_hit;
            snap_any = bus.out_any_hit;
            stable   = 1'b1;
            repeat (stall) begin
                @(posedge clk); #1;
                if (!bus.out_valid || bus.out_hit !== snap || bus.out_any_hit !== snap_any || bus.ray_in_ready)
                    stable = 1'b0;
            end
            chk($sformatf("stall_stable_%0d", id), stable, 1);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk($sformatf("release_%0d", id), {bus.out_valid, bus.ray_in_ready}, 2'b01);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.ray_in_valid = 1'b0;
        bus.ray_in       = '0;
        bus.any_hit_mode = 1'b0;
        bus.num_batches  = '0;
        bus.out_ready    = 1'b0;
        clr_tab();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {bus.ray_in_ready, bus.prim_rd_en, bus.out_valid, bus.out_any_hit}, 4'b1000);
        chk("rst_addr", bus.prim_addr, 0);
        chk("rst_hit", bus.out_hit, MISS);
        chk("rst_ray", bus.ray_out == '0, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Closest: 5.0, 2.0, 7.0 -> batch 1, latency 1+3+2
        clr_tab();
        set_b(0, 1, fx(5), 24'hC00000);
        set_b(1, 1, fx(2), 24'hC00001);
        set_b(2, 1, fx(7), 24'hC00002);
        run_ray(1, 0, 3, hd(1, fx(2), 24'hC00001), 1, 6, 3, 3, 0);

        // Tie on T=3.0: earlier batch keeps its color
        clr_tab();
        set_b(0, 1, fx(3), 24'hAAAA01);
        set_b(1, 1, fx(3), 24'hBBBB02);
        run_ray(2, 0, 2, hd(1, fx(3), 24'hAAAA01), 1, 5, 2, 2, 0);

        // Signed compare, misses with small T ignored
        clr_tab();
        set_b(0, 0, fx(1),  24'h000010);
        set_b(1, 1, fx(-2), 24'h000011);
        set_b(2, 1, fx(4),  24'h000012);
        set_b(3, 0, fx(-5), 24'h000013);
        run_ray(3, 0, 4, hd(1, fx(-2), 24'h000011), 1, 7, 4, 4, 0);

        // Closest, all miss
        clr_tab();
        run_ray(4, 0, 3, MISS, 0, 6, 3, 3, 0);

        // Any-hit, hit only in batch 2: early out, at most indices 0..4
        clr_tab();
        set_b(2, 1, fx(4), 24'h00AA02);
        run_ray(5, 1, 8, MISS, 1, -1, 3, 5, 0);

        // Any-hit, no hit: full walk
        clr_tab();
        run_ray(6, 1, 3, MISS, 0, 6, 3, 3, 0);

        // Zero batches: DONE right after accept, nothing fetched
        run_ray(7, 0, 0, MISS, 0, 1, 0, 0, 0);

        // Result held under back-pressure for 5 cycles
        clr_tab();
        set_b(0, 1, fx(8), 24'h5A0000);
        set_b(1, 1, fx(6), 24'h5A0001);
        run_ray(8, 0, 2, hd(1, fx(6), 24'h5A0001), 1, 5, 2, 2, 5);

        // Maximum batch count, table repeats every 8 batches
        for (int i = 0; i < 8; i++) set_b(i, 1, fx(10 + i), 24'hE00000 | 24'(i));
        set_b(5, 1, fx(1), 24'hE00005);
        run_ray(9, 0, 255, hd(1, fx(1), 24'hE00005), 1, 258, 255, 255, 0);

        // Reset in the middle of issue, after a near hit already retired
        clr_tab();
        set_b(0, 1, 32'sh0000_8000, 24'h111111);
        bus.ray_in       = '{ox: fx(3), oy: fx(3), oz: fx(3), dx: fx(1), dy: fx(1), dz: fx(1)};
        bus.any_hit_mode = 1'b0;
        bus.num_batches  = 8'd8;
        bus.out_ready    = 1'b1;
        bus.ray_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.ray_in_valid = 1'b0;
        t = 0;
        while (!(bus.prim_rd_en && bus.prim_addr == 8'd4) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_idx4", {bus.prim_rd_en, bus.prim_addr}, {1'b1, 8'd4});
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", {bus.ray_in_ready, bus.prim_rd_en, bus.out_valid, bus.out_any_hit}, 4'b1000);
        chk("midrst_addr", bus.prim_addr, 0);
        chk("midrst_hit", bus.out_hit, MISS);
        chk("midrst_ray", bus.ray_out == '0, 1);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Clean restart: no stale 0.5 from the aborted ray
        clr_tab();
        set_b(0, 1, fx(9), 24'h220000);
        set_b(1, 1, fx(6), 24'h220001);
        run_ray(10, 0, 2, hd(1, fx(6), 24'h220001), 1, 5, 2, 2, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
